reg16_write_arbiter: RTL and testbench
======================================

Name: reg16_write_arbiter

Overview:
- Shares one 16-bit CPU register between NREQ write requesters, e.g. the fetch/decode path, the ALU writeback and the debug port.
- Selects one writer per cycle with round-robin priority and loads that writer's data into the register it owns internally.
- Supports a bounded multi-cycle lock so that one requester can perform back-to-back writes without interleaving.
- Returns a registered per-requester ack and the current register value.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 16, data width of the shared register
LOCK_MAX, 8, maximum consecutive LOCKED-state cycles before forced release (>=1)

Ports:
clock  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  write request, one bit per requester
lock  in  NREQ  lock request, honoured only together with a granted req
wdata  in  NREQ*WIDTH  packed write data, requester i at [i*WIDTH +: WIDTH]
ack  out  NREQ  registered one-hot write acknowledge
q  out  WIDTH  current register contents
locked  out  1  high while in LOCKED state
owner  out  clog2(NREQ)  lock owner index, valid when locked=1
lock_timeout  out  1  one-cycle pulse on forced lock release

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: rst_n=0 immediately forces the following, including mid-lock.
  - q=0, ack=0, locked=0, owner=0, lock_timeout=0
  - rr pointer ptr=0, lock counter cnt=0, state=IDLE
- Arbitration is combinational within the cycle. The write and all outputs update at the rising edge.
- Latency: requester i is granted in cycle t, so q=wdata_i and ack[i]=1 during cycle t+1. ack is at most one-hot.
- Requester handshake:
  - Hold req and wdata stable until ack is seen.
  - Keeping req high through ack requests a further write.
  - Deasserting req before ack withdraws the request with no write.
- IDLE state:
  - Winner is the first i with req[i]=1, scanning ptr, ptr+1, … mod NREQ.
  - On a grant to i, ptr <= (i+1) mod NREQ.
  - If lock[i]=1 in the grant cycle: state <= LOCKED, owner <= i, cnt <= 0.
  - No req: no write, ack=0, ptr unchanged.
- LOCKED state:
  - Only owner is considered; req from others is ignored, so they stall.
  - owner req=1: write and ack each cycle. owner req=0: no write, lock still held.
  - cnt increments each LOCKED cycle.
  - Voluntary release: if lock[owner]=0 at an edge, state <= IDLE at that edge; that cycle's write still occurs if req[owner]=1.
  - ptr <= owner+1 on any release.
  - Forced release: if cnt==LOCK_MAX-1 and lock[owner]=1, state <= IDLE and lock_timeout=1 for the next cycle only.
  - The owner therefore receives at most 1+LOCK_MAX consecutive grants.
- lock without req, or lock from a non-winner: ignored.
- After any release, the former owner may re-lock only when round-robin selects it again.
- Out-of-range owner cannot occur (NREQ need not be a power of two; the scan wraps at NREQ).

Decomposition:
- Shared package holds:
  - state enum {IDLE, LOCKED}
  - default parameter constants
  - helper function for the clog2 width
- One sub-module, rr_pick: combinational round-robin selector. Inputs: req vector and ptr. Outputs: one-hot grant and index.
- The top level holds the FSM, counter, ptr, ack/q registers and write mux.

Test Plan:
- Reset: drive req=4'b1111 with rst_n=0 -> q=0, ack=0, locked=0, lock_timeout=0. Deassert rst_n -> first ack[0] one cycle later, q=wdata0.
- Round-robin: req=4'b1111 held, wdata_i=16'h1000+i -> acks cycle 0,1,2,3,0; q sequence 1000,1001,1002,1003,1000.
- Single requester: only req[2] held 3 cycles with data 16'hABCD, 16'h1234, 16'h5555 -> ack[2] on 3 consecutive cycles, q follows one cycle behind.
- Lock: req[1]+lock[1] for 3 cycles, then lock[1]=0 with req[1]=0, req[3] held throughout -> ack[1] x3, locked=1 for cycles 2-3 with owner=1, then ack[3]. req[3] never acked while locked.
- Timeout with LOCK_MAX=4: req[0]+lock[0] held forever, req[2] held -> 5 ack[0], lock_timeout pulse, next grant ack[2].
- Reset mid-lock: assert rst_n=0 while locked=1, owner=2 -> locked, owner, q and ack go 0 asynchronously before the next clock edge. After release, the first grant is chosen from ptr=0.

Source files
------------

// File: rtl/reg16_write_arbiter_pkg.sv
// Shared types and constants for the reg16 write arbiter.
// Holds the FSM state type and the index-width helper.
package reg16_write_arbiter_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    localparam int NREQ_DEF     = 4;
    localparam int WIDTH_DEF    = 16;
    localparam int LOCK_MAX_DEF = 8;

    // Minimum 1 bit so single-value ranges still give a legal vector.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/reg16_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester found scanning
// ptr, ptr+1, ... wrapping at NREQ.
module rr_pick
    import reg16_write_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = idx_width(NREQ_DEF)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!valid && req[(int'(ptr) + k) % NREQ]) begin
                valid = 1'b1;
                idx   = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign grant = valid ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/reg16_write_arbiter.sv
// Round-robin write arbiter for one shared register, with a bounded
// lock that lets one requester issue back-to-back writes.
module reg16_write_arbiter
    import reg16_write_arbiter_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic                         clock,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ-1:0]              lock,
    input  logic [NREQ*WIDTH-1:0]        wdata,
    output logic [NREQ-1:0]              ack,
    output logic [WIDTH-1:0]             q,
    output logic                         locked,
    output logic [idx_width(NREQ)-1:0]   owner,
    output logic                         lock_timeout
);

    localparam int IW = idx_width(NREQ);
    localparam int CW = idx_width(LOCK_MAX);
    localparam logic [CW-1:0] CMAX = CW'(LOCK_MAX - 1);

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [IW-1:0]   owner_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [NREQ-1:0] ack_n;
    logic            tmo_n;
    logic            wr_en;
    logic [IW-1:0]   wr_idx;
    logic [WIDTH-1:0] wsel;

    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + IW'(1);
    endfunction

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign wsel   = wdata[int'(wr_idx)*WIDTH +: WIDTH];
    assign locked = (state == LOCKED);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        cnt_n   = cnt;
        ack_n   = '0;
        tmo_n   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = pick_idx;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    wr_en = 1'b1;
                    ack_n = pick_grant;
                    ptr_n = nxt(pick_idx);
                    if (lock[pick_idx]) begin
                        state_n = LOCKED;
                        owner_n = pick_idx;
                        cnt_n   = '0;
                    end
                end
            end
            LOCKED: begin
                wr_idx = owner;
                cnt_n  = cnt + CW'(1);
                if (req[owner]) begin
                    wr_en = 1'b1;
                    ack_n = NREQ'(1) << owner;
                end
                // Release always hands the pointer past the owner.
                if (!lock[owner]) begin
                    state_n = IDLE;
                    ptr_n   = nxt(owner);
                end else if (cnt == CMAX) begin
                    state_n = IDLE;
                    ptr_n   = nxt(owner);
                    tmo_n   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            cnt          <= '0;
            owner        <= '0;
            ack          <= '0;
            lock_timeout <= 1'b0;
            q            <= '0;
        end else begin
            ptr          <= ptr_n;
            cnt          <= cnt_n;
            owner        <= owner_n;
            ack          <= ack_n;
            lock_timeout <= tmo_n;
            if (wr_en) q <= wsel;
        end
    end

endmodule

// File: tb/tb_reg16_write_arbiter.sv
// Directed bench for reg16_write_arbiter (NREQ=4, WIDTH=16, LOCK_MAX=4).
// Expected values are hand-derived per cycle.
module tb_reg16_write_arbiter;

    logic        clock;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [63:0] wdata;
    logic [3:0]  ack;
    logic [15:0] q;
    logic        locked;
    logic [1:0]  owner;
    logic        lock_timeout;

    int checks;
    int failures;

    reg16_write_arbiter #(
        .NREQ     (4),
        .WIDTH    (16),
        .LOCK_MAX (4)
    ) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .req          (req),
        .lock         (lock),
        .wdata        (wdata),
        .ack          (ack),
        .q            (q),
        .locked       (locked),
        .owner        (owner),
        .lock_timeout (lock_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic expect_eq(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_wd(input int i, input logic [15:0] v);
        wdata[i*16 +: 16] = v;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] a,
                             input logic [15:0] qv, input logic lk,
                             input logic tmo);
        expect_eq({tag, ".ack"}, 32'(ack), 32'(a));
        expect_eq({tag, ".q"}, 32'(q), 32'(qv));
        expect_eq({tag, ".locked"}, 32'(locked), 32'(lk));
        expect_eq({tag, ".tmo"}, 32'(lock_timeout), 32'(tmo));
    endtask

    logic [3:0]  rr_ack [5];
    logic [15:0] rr_q   [5];

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = 4'b1111;
        lock     = 4'b0000;
        for (int i = 0; i < 4; i++) set_wd(i, 16'h1000 + 16'(i));

        // Reset holds everything at zero, even across a clock edge.
        #2;
        chk_state("rst0", 4'b0000, 16'h0000, 1'b0, 1'b0);
        expect_eq("rst0.owner", 32'(owner), 32'd0);
        step();
        chk_state("rst1", 4'b0000, 16'h0000, 1'b0, 1'b0);

        // Round-robin over all four.
        rr_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_q   = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1000};
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk_state($sformatf("rr%0d", c), rr_ack[c], rr_q[c], 1'b0, 1'b0);
        end

        // Single requester, changing data.
        do_reset();
        req = 4'b0100;
        set_wd(2, 16'hABCD);
        step();
        chk_state("one0", 4'b0100, 16'hABCD, 1'b0, 1'b0);
        set_wd(2, 16'h1234);
        step();
        chk_state("one1", 4'b0100, 16'h1234, 1'b0, 1'b0);
        set_wd(2, 16'h5555);
        step();
        chk_state("one2", 4'b0100, 16'h5555, 1'b0, 1'b0);
        req = 4'b0000;
        step();
        chk_state("one3", 4'b0000, 16'h5555, 1'b0, 1'b0);

        // Voluntary lock by requester 1; requester 3 stalls.
        do_reset();
        set_wd(1, 16'h0111);
        set_wd(3, 16'h0333);
        req  = 4'b1010;
        lock = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_state($sformatf("lk%0d", c), 4'b0010, 16'h0111, 1'b1, 1'b0);
            expect_eq($sformatf("lk%0d.owner", c), 32'(owner), 32'd1);
        end
        req  = 4'b1000;
        lock = 4'b0000;
        step();
        chk_state("lk3", 4'b0000, 16'h0111, 1'b0, 1'b0);
        step();
        chk_state("lk4", 4'b1000, 16'h0333, 1'b0, 1'b0);

        // Forced release after 1+LOCK_MAX grants.
        do_reset();
        set_wd(0, 16'h0AAA);
        set_wd(2, 16'h0CCC);
        req  = 4'b0101;
        lock = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_state($sformatf("to%0d", c), 4'b0001, 16'h0AAA, 1'b1, 1'b0);
        end
        step();
        chk_state("to4", 4'b0001, 16'h0AAA, 1'b0, 1'b1);
        step();
        chk_state("to5", 4'b0100, 16'h0CCC, 1'b0, 1'b0);

        // Asynchronous reset while locked to requester 2.
        do_reset();
        set_wd(0, 16'h0F00);
        set_wd(2, 16'h0F22);
        req  = 4'b0100;
        lock = 4'b0100;
        step();
        step();
        chk_state("ml0", 4'b0100, 16'h0F22, 1'b1, 1'b0);
        expect_eq("ml0.owner", 32'(owner), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("ml1", 4'b0000, 16'h0000, 1'b0, 1'b0);
        expect_eq("ml1.owner", 32'(owner), 32'd0);
        req  = 4'b1111;
        lock = 4'b0000;
        #1;
        rst_n = 1'b1;
        step();
        chk_state("ml2", 4'b0001, 16'h0F00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
